// File: rtl/name_dual_issue_dispatcher_if.sv
// Purpose: word stream in, two lane name outputs, overlength flag for the dual-issue dispatcher.
// Latency: none (wires only).
// Backpressure: word_in_ready toward upstream; name_out_ready_1/2 from the lane consumers.
interface name_dual_issue_dispatcher_if #(
    parameter int WORD_SIZE       = 32,
    parameter int MAX_NAME_LENGTH = 8,
    parameter int LEN_W           = 4
);
    logic [WORD_SIZE-1:0]                 word_in;
    logic                                 word_in_valid;
    logic                                 word_in_last;
    logic                                 word_in_ready;
    logic [WORD_SIZE*MAX_NAME_LENGTH-1:0] name_out_1;
    logic [LEN_W-1:0]                     name_len_out_1;
    logic                                 name_out_valid_1;
    logic                                 name_out_ready_1;
    logic [WORD_SIZE*MAX_NAME_LENGTH-1:0] name_out_2;
    logic [LEN_W-1:0]                     name_len_out_2;
    logic                                 name_out_valid_2;
    logic                                 name_out_ready_2;
    logic                                 overlength_err_out;

    // Upstream feeder plus lane consumers.
    modport master (
        output word_in, word_in_valid, word_in_last, name_out_ready_1, name_out_ready_2,
        input  word_in_ready, name_out_1, name_len_out_1, name_out_valid_1,
        input  name_out_2, name_len_out_2, name_out_valid_2, overlength_err_out
    );

    // The dispatcher itself.
    modport slave (
        input  word_in, word_in_valid, word_in_last, name_out_ready_1, name_out_ready_2,
        output word_in_ready, name_out_1, name_len_out_1, name_out_valid_1,
        output name_out_2, name_len_out_2, name_out_valid_2, overlength_err_out
    );
endinterface

// File: rtl/name_dual_issue_dispatcher.sv
// Purpose: assemble 32-bit name words into padded name vectors and issue them to two lanes in strict alternation.
// Latency: lane valid rises 1 cycle after the final (or truncating) word is accepted.
// Backpressure: if the target lane is full the name parks in HOLD and word_in_ready drops until it drains.
module name_dual_issue_dispatcher #(
    parameter int WORD_SIZE       = 32,
    parameter int MAX_NAME_LENGTH = 8,
    parameter int LEN_W           = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    name_dual_issue_dispatcher_if.slave  bus
);
    localparam int                NAME_W   = WORD_SIZE * MAX_NAME_LENGTH;
    localparam logic [LEN_W-1:0]  LAST_IDX = LEN_W'(MAX_NAME_LENGTH - 1);

    typedef enum logic [1:0] {
        ST_ASSEMBLE = 2'd0,
        ST_HOLD     = 2'd1,
        ST_DISCARD  = 2'd2
    } state_t;

    state_t              state;
    logic                rdy_q;
    logic [LEN_W-1:0]    widx;
    logic                rr_lane2;
    logic                pending_discard;
    logic [NAME_W-1:0]   asm_name;
    logic [LEN_W-1:0]    asm_len;
    logic                err_q;

    logic [NAME_W-1:0]   name_1_q;
    logic [LEN_W-1:0]    len_1_q;
    logic                vld_1_q;
    logic [NAME_W-1:0]   name_2_q;
    logic [LEN_W-1:0]    len_2_q;
    logic                vld_2_q;

    logic                accept;
    logic                complete;
    logic                overlen;
    logic                pop_1;
    logic                pop_2;
    logic                tgt_free;
    logic                issue;
    logic                load_1;
    logic                load_2;
    logic [NAME_W-1:0]   cur_name;
    logic [LEN_W-1:0]    cur_len;
    logic [NAME_W-1:0]   load_name;
    logic [LEN_W-1:0]    load_len;

    assign accept   = bus.word_in_valid & rdy_q;
    assign complete = accept & (state == ST_ASSEMBLE) & (bus.word_in_last | (widx == LAST_IDX));
    assign overlen  = complete & ~bus.word_in_last & (widx == LAST_IDX);
    assign pop_1    = vld_1_q & bus.name_out_ready_1;
    assign pop_2    = vld_2_q & bus.name_out_ready_2;
    // A lane can take a name if it is empty or being drained at this same edge.
    assign tgt_free = rr_lane2 ? (~vld_2_q | pop_2) : (~vld_1_q | pop_1);
    assign issue    = tgt_free & (complete | (state == ST_HOLD));
    assign load_1   = issue & ~rr_lane2;
    assign load_2   = issue &  rr_lane2;
    assign cur_len  = widx + LEN_W'(1);

    // Merge the incoming word into the name; word 0 of a new name starts from a cleared vector.
    always_comb begin
        cur_name = (widx == '0) ? '0 : asm_name;
        for (int k = 0; k < MAX_NAME_LENGTH; k++) begin
            if (widx == LEN_W'(k)) begin
                cur_name[WORD_SIZE*(MAX_NAME_LENGTH-k)-1 -: WORD_SIZE] = bus.word_in;
            end
        end
    end

    // A parked name comes from the assembly register, a fresh one straight from the merge.
    always_comb begin
        load_name = cur_name;
        load_len  = cur_len;
        if (state == ST_HOLD) begin
            load_name = asm_name;
            load_len  = asm_len;
        end
    end

    // Control FSM: assembly, hold on a blocked lane, discard of overlength tails.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= ST_ASSEMBLE;
            rdy_q           <= 1'b0;
            widx            <= '0;
            rr_lane2        <= 1'b0;
            pending_discard <= 1'b0;
            asm_name        <= '0;
            asm_len         <= '0;
            err_q           <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            err_q <= overlen;
            case (state)
                ST_ASSEMBLE: begin
                    if (accept) begin
                        asm_name <= cur_name;
                        asm_len  <= cur_len;
                        if (complete) begin
                            widx <= '0;
                            if (tgt_free) begin
                                rr_lane2 <= ~rr_lane2;
                                state    <= overlen ? ST_DISCARD : ST_ASSEMBLE;
                            end else begin
                                state           <= ST_HOLD;
                                pending_discard <= overlen;
                                rdy_q           <= 1'b0;
                            end
                        end else begin
                            widx <= cur_len;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tgt_free) begin
                        rr_lane2        <= ~rr_lane2;
                        pending_discard <= 1'b0;
                        state           <= pending_discard ? ST_DISCARD : ST_ASSEMBLE;
                    end else begin
                        rdy_q <= 1'b0;
                    end
                end
                ST_DISCARD: begin
                    if (accept & bus.word_in_last) begin
                        state <= ST_ASSEMBLE;
                    end
                end
                default: begin
                    state <= ST_ASSEMBLE;
                end
            endcase
        end
    end

    // Lane 1 holding register: reload wins over pop so a same-edge refill leaves valid high.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            name_1_q <= '0;
            len_1_q  <= '0;
            vld_1_q  <= 1'b0;
        end else if (load_1) begin
            name_1_q <= load_name;
            len_1_q  <= load_len;
            vld_1_q  <= 1'b1;
        end else if (pop_1) begin
            vld_1_q  <= 1'b0;
        end
    end

    // Lane 2 holding register, same policy as lane 1.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            name_2_q <= '0;
            len_2_q  <= '0;
            vld_2_q  <= 1'b0;
        end else if (load_2) begin
            name_2_q <= load_name;
            len_2_q  <= load_len;
            vld_2_q  <= 1'b1;
        end else if (pop_2) begin
            vld_2_q  <= 1'b0;
        end
    end

    assign bus.word_in_ready      = rdy_q;
    assign bus.name_out_1         = name_1_q;
    assign bus.name_len_out_1     = len_1_q;
    assign bus.name_out_valid_1   = vld_1_q;
    assign bus.name_out_2         = name_2_q;
    assign bus.name_len_out_2     = len_2_q;
    assign bus.name_out_valid_2   = vld_2_q;
    assign bus.overlength_err_out = err_q;
endmodule

// File: tb/tb_name_dual_issue_dispatcher.sv
// Purpose: directed self-checking bench for the dual-issue name dispatcher.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: lane readies driven per scenario; every word send is bounded by a cycle budget.
module tb_name_dual_issue_dispatcher;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    name_dual_issue_dispatcher_if #(.WORD_SIZE(32), .MAX_NAME_LENGTH(8), .LEN_W(4)) bus ();

    name_dual_issue_dispatcher #(.WORD_SIZE(32), .MAX_NAME_LENGTH(8), .LEN_W(4)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    // Expected name: n consecutive words starting at base, word 0 in the MSBs, zero padded.
    function automatic logic [255:0] mk(input logic [31:0] base, input int n);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[255-32*k -: 32] = base + 32'(k);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word and return 1 time unit after the edge that accepts it.
    task automatic send(input logic [31:0] w, input logic last);
        int t;
        bus.word_in       = w;
        bus.word_in_valid = 1'b1;
        bus.word_in_last  = last;
        t = 0;
        while (bus.word_in_ready !== 1'b1 && t < 64) begin
            tick();
            t++;
        end
        n_checks++;
        if (t >= 64) begin
            n_fail++;
            $display("FAIL send_timeout: word_in_ready=%b required 1 for word %h", bus.word_in_ready, w);
        end
        tick();
        bus.word_in_valid = 1'b0;
        bus.word_in_last  = 1'b0;
    endtask

    task automatic do_reset();
        bus.word_in_valid    = 1'b0;
        bus.word_in_last     = 1'b0;
        bus.word_in          = '0;
        bus.name_out_ready_1 = 1'b0;
        bus.name_out_ready_2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        bus.word_in_valid    = 1'b0;
        bus.word_in_last     = 1'b0;
        bus.word_in          = '0;
        bus.name_out_ready_1 = 1'b0;
        bus.name_out_ready_2 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.word_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", bus.word_in_ready); end
        n_checks++; if (bus.name_out_valid_1 !== 1'b0 || bus.name_out_valid_2 !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b%b want 00", bus.name_out_valid_1, bus.name_out_valid_2); end
        n_checks++; if (bus.name_out_1 !== '0 || bus.name_out_2 !== '0 || bus.name_len_out_1 !== 4'd0 || bus.name_len_out_2 !== 4'd0) begin n_fail++; $display("FAIL rst_data: got %h/%h want 0", bus.name_out_1, bus.name_out_2); end
        n_checks++; if (bus.overlength_err_out !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.overlength_err_out); end
        tick();
        n_checks++; if (bus.word_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_held: got %b want 0", bus.word_in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus.word_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_release: got %b want 1", bus.word_in_ready); end
    endtask

    task automatic test_single_name();
        do_reset();
        bus.name_out_ready_1 = 1'b1;
        bus.name_out_ready_2 = 1'b1;
        send(32'hA1A1_0001, 1'b0);
        send(32'hA2A2_0002, 1'b0);
        n_checks++; if (bus.name_out_valid_1 !== 1'b0) begin n_fail++; $display("FAIL t1_early_valid: got %b want 0", bus.name_out_valid_1); end
        send(32'hA3A3_0003, 1'b1);
        n_checks++; if (bus.name_out_valid_1 !== 1'b1) begin n_fail++; $display("FAIL t1_valid1: got %b want 1", bus.name_out_valid_1); end
        n_checks++; if (bus.name_out_1 !== {32'hA1A1_0001, 32'hA2A2_0002, 32'hA3A3_0003, 160'h0}) begin n_fail++; $display("FAIL t1_name1: got %h want A1A1_0001 A2A2_0002 A3A3_0003 then zeros", bus.name_out_1); end
        n_checks++; if (bus.name_len_out_1 !== 4'd3) begin n_fail++; $display("FAIL t1_len1: got %0d want 3", bus.name_len_out_1); end
        n_checks++; if (bus.name_out_valid_2 !== 1'b0) begin n_fail++; $display("FAIL t1_valid2: got %b want 0", bus.name_out_valid_2); end
        tick();
        n_checks++; if (bus.name_out_valid_1 !== 1'b0) begin n_fail++; $display("FAIL t1_pop1: got %b want 0", bus.name_out_valid_1); end
    endtask

    task automatic test_back_to_back_hold();
        do_reset();
        send(32'h100, 1'b0); send(32'h101, 1'b1);
        send(32'h200, 1'b0); send(32'h201, 1'b1);
        send(32'h300, 1'b0); send(32'h301, 1'b1);
        n_checks++; if (bus.word_in_ready !== 1'b0) begin n_fail++; $display("FAIL t2_hold_ready: got %b want 0", bus.word_in_ready); end
        n_checks++; if (bus.name_out_valid_1 !== 1'b1 || bus.name_out_1 !== mk(32'h100, 2)) begin n_fail++; $display("FAIL t2_lane1_n0: got %b %h want 1 %h", bus.name_out_valid_1, bus.name_out_1, mk(32'h100, 2)); end
        n_checks++; if (bus.name_out_valid_2 !== 1'b1 || bus.name_out_2 !== mk(32'h200, 2)) begin n_fail++; $display("FAIL t2_lane2_n1: got %b %h want 1 %h", bus.name_out_valid_2, bus.name_out_2, mk(32'h200, 2)); end
        bus.word_in = 32'h400; bus.word_in_valid = 1'b1;
        tick();
        n_checks++; if (bus.word_in_ready !== 1'b0 || bus.name_out_1 !== mk(32'h100, 2)) begin n_fail++; $display("FAIL t2_hold_stable: got rdy=%b %h want rdy=0 %h", bus.word_in_ready, bus.name_out_1, mk(32'h100, 2)); end
        bus.name_out_ready_1 = 1'b1;
        tick();
        n_checks++; if (bus.name_out_valid_1 !== 1'b1 || bus.name_out_1 !== mk(32'h300, 2) || bus.name_len_out_1 !== 4'd2) begin n_fail++; $display("FAIL t2_n2_lane1: got %b %h len %0d want 1 %h len 2", bus.name_out_valid_1, bus.name_out_1, bus.name_len_out_1, mk(32'h300, 2)); end
        n_checks++; if (bus.word_in_ready !== 1'b1) begin n_fail++; $display("FAIL t2_ready_after_hold: got %b want 1", bus.word_in_ready); end
        send(32'h400, 1'b0); send(32'h401, 1'b1);
        tick();
        n_checks++; if (bus.name_out_valid_1 !== 1'b0 || bus.word_in_ready !== 1'b0) begin n_fail++; $display("FAIL t2_no_bypass: got valid1=%b rdy=%b want 0 0", bus.name_out_valid_1, bus.word_in_ready); end
        bus.name_out_ready_2 = 1'b1;
        tick();
        n_checks++; if (bus.name_out_valid_2 !== 1'b1 || bus.name_out_2 !== mk(32'h400, 2)) begin n_fail++; $display("FAIL t2_n3_lane2: got %b %h want 1 %h", bus.name_out_valid_2, bus.name_out_2, mk(32'h400, 2)); end
        bus.name_out_ready_1 = 1'b0;
        bus.name_out_ready_2 = 1'b0;
    endtask

    task automatic test_overlength();
        do_reset();
        for (int k = 0; k < 7; k++) send(32'h1000 + 32'(k), 1'b0);
        n_checks++; if (bus.name_out_valid_1 !== 1'b0 || bus.overlength_err_out !== 1'b0) begin n_fail++; $display("FAIL t3_before_trunc: got valid=%b err=%b want 0 0", bus.name_out_valid_1, bus.overlength_err_out); end
        send(32'h1007, 1'b0);
        n_checks++; if (bus.name_out_valid_1 !== 1'b1 || bus.name_out_1 !== mk(32'h1000, 8)) begin n_fail++; $display("FAIL t3_trunc_name: got %b %h want 1 %h", bus.name_out_valid_1, bus.name_out_1, mk(32'h1000, 8)); end
        n_checks++; if (bus.name_len_out_1 !== 4'd8) begin n_fail++; $display("FAIL t3_trunc_len: got %0d want 8", bus.name_len_out_1); end
        n_checks++; if (bus.overlength_err_out !== 1'b1) begin n_fail++; $display("FAIL t3_err_pulse: got %b want 1", bus.overlength_err_out); end
        send(32'h1008, 1'b0);
        n_checks++; if (bus.overlength_err_out !== 1'b0 || bus.word_in_ready !== 1'b1) begin n_fail++; $display("FAIL t3_err_once: got err=%b rdy=%b want 0 1", bus.overlength_err_out, bus.word_in_ready); end
        send(32'h1009, 1'b1);
        n_checks++; if (bus.name_out_valid_2 !== 1'b0) begin n_fail++; $display("FAIL t3_tail_dropped: got %b want 0", bus.name_out_valid_2); end
        send(32'h0ABC, 1'b1);
        n_checks++; if (bus.name_out_valid_2 !== 1'b1 || bus.name_out_2 !== {32'h0ABC, 224'h0} || bus.name_len_out_2 !== 4'd1) begin n_fail++; $display("FAIL t3_next_lane2: got %b %h len %0d want 1 00000ABC then zeros len 1", bus.name_out_valid_2, bus.name_out_2, bus.name_len_out_2); end
        n_checks++; if (bus.name_out_1 !== mk(32'h1000, 8)) begin n_fail++; $display("FAIL t3_lane1_stable: got %h want %h", bus.name_out_1, mk(32'h1000, 8)); end
    endtask

    task automatic test_exact_max();
        do_reset();
        for (int k = 0; k < 8; k++) send(32'h2000 + 32'(k), (k == 7));
        n_checks++; if (bus.overlength_err_out !== 1'b0 || bus.name_len_out_1 !== 4'd8 || bus.name_out_1 !== mk(32'h2000, 8)) begin n_fail++; $display("FAIL t3b_exact: got err=%b len=%0d %h want 0 8 %h", bus.overlength_err_out, bus.name_len_out_1, bus.name_out_1, mk(32'h2000, 8)); end
        tick();
        n_checks++; if (bus.overlength_err_out !== 1'b0) begin n_fail++; $display("FAIL t3b_no_err: got %b want 0", bus.overlength_err_out); end
        send(32'h3000, 1'b1);
        n_checks++; if (bus.name_out_valid_2 !== 1'b1 || bus.name_out_2 !== {32'h3000, 224'h0}) begin n_fail++; $display("FAIL t3b_next_name: got %b %h want 1 00003000 then zeros", bus.name_out_valid_2, bus.name_out_2); end
    endtask

    task automatic test_overlength_hold();
        do_reset();
        send(32'h10, 1'b1);
        send(32'h20, 1'b1);
        for (int k = 0; k < 8; k++) send(32'h5000 + 32'(k), 1'b0);
        n_checks++; if (bus.overlength_err_out !== 1'b1 || bus.word_in_ready !== 1'b0) begin n_fail++; $display("FAIL t3c_hold_err: got err=%b rdy=%b want 1 0", bus.overlength_err_out, bus.word_in_ready); end
        tick();
        n_checks++; if (bus.overlength_err_out !== 1'b0) begin n_fail++; $display("FAIL t3c_err_once: got %b want 0", bus.overlength_err_out); end
        bus.name_out_ready_1 = 1'b1;
        tick();
        bus.name_out_ready_1 = 1'b0;
        n_checks++; if (bus.name_out_1 !== mk(32'h5000, 8) || bus.name_len_out_1 !== 4'd8 || bus.word_in_ready !== 1'b1) begin n_fail++; $display("FAIL t3c_release: got %h len %0d rdy %b want %h len 8 rdy 1", bus.name_out_1, bus.name_len_out_1, bus.word_in_ready, mk(32'h5000, 8)); end
        bus.name_out_ready_2 = 1'b1;
        send(32'h5008, 1'b0);
        send(32'h5009, 1'b1);
        send(32'h6000, 1'b1);
        n_checks++; if (bus.name_out_valid_2 !== 1'b1 || bus.name_out_2 !== {32'h6000, 224'h0}) begin n_fail++; $display("FAIL t3c_discard_then_lane2: got %b %h want 1 00006000 then zeros", bus.name_out_valid_2, bus.name_out_2); end
        bus.name_out_ready_2 = 1'b0;
    endtask

    task automatic test_reload_same_edge();
        do_reset();
        bus.name_out_ready_2 = 1'b1;
        send(32'h70, 1'b1);
        send(32'h80, 1'b1);
        send(32'h90, 1'b0);
        n_checks++; if (bus.name_out_valid_1 !== 1'b1 || bus.name_out_1 !== {32'h70, 224'h0}) begin n_fail++; $display("FAIL t4_lane1_before: got %b %h want 1 00000070 then zeros", bus.name_out_valid_1, bus.name_out_1); end
        bus.name_out_ready_1 = 1'b1;
        send(32'h91, 1'b1);
        n_checks++; if (bus.name_out_valid_1 !== 1'b1 || bus.name_out_1 !== mk(32'h90, 2) || bus.name_len_out_1 !== 4'd2) begin n_fail++; $display("FAIL t4_reload: got %b %h len %0d want 1 %h len 2", bus.name_out_valid_1, bus.name_out_1, bus.name_len_out_1, mk(32'h90, 2)); end
        tick();
        n_checks++; if (bus.name_out_valid_1 !== 1'b0) begin n_fail++; $display("FAIL t4_drain: got %b want 0", bus.name_out_valid_1); end
        bus.name_out_ready_1 = 1'b0;
        bus.name_out_ready_2 = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        send(32'h11, 1'b1);
        for (int k = 0; k < 4; k++) send(32'h0C00 + 32'(k), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.name_out_valid_1 !== 1'b0 || bus.name_out_1 !== '0 || bus.name_len_out_1 !== 4'd0 || bus.word_in_ready !== 1'b0) begin n_fail++; $display("FAIL t5_mid_name_rst: got v=%b len=%0d rdy=%b want all 0", bus.name_out_valid_1, bus.name_len_out_1, bus.word_in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send(32'h0D00, 1'b0);
        send(32'h0D01, 1'b1);
        n_checks++; if (bus.name_out_valid_1 !== 1'b1 || bus.name_out_1 !== mk(32'h0D00, 2) || bus.name_len_out_1 !== 4'd2) begin n_fail++; $display("FAIL t5_clean_pad: got %b %h len %0d want 1 %h len 2", bus.name_out_valid_1, bus.name_out_1, bus.name_len_out_1, mk(32'h0D00, 2)); end
        send(32'h0E0, 1'b1);
        send(32'h0F0, 1'b1);
        n_checks++; if (bus.word_in_ready !== 1'b0 || bus.name_out_valid_2 !== 1'b1) begin n_fail++; $display("FAIL t5_in_hold: got rdy=%b v2=%b want 0 1", bus.word_in_ready, bus.name_out_valid_2); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.name_out_valid_1 !== 1'b0 || bus.name_out_valid_2 !== 1'b0 || bus.name_out_2 !== '0 || bus.word_in_ready !== 1'b0) begin n_fail++; $display("FAIL t5_hold_rst: got v1=%b v2=%b rdy=%b want 0 0 0", bus.name_out_valid_1, bus.name_out_valid_2, bus.word_in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send(32'h0AA, 1'b1);
        n_checks++; if (bus.name_out_valid_1 !== 1'b1 || bus.name_out_1 !== {32'h0AA, 224'h0} || bus.name_out_valid_2 !== 1'b0) begin n_fail++; $display("FAIL t5_first_lane1: got v1=%b %h v2=%b want 1 000000AA then zeros 0", bus.name_out_valid_1, bus.name_out_1, bus.name_out_valid_2); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_name();
        test_back_to_back_hold();
        test_overlength();
        test_exact_max();
        test_overlength_hold();
        test_reload_same_edge();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
